// File: rtl/if_id_skid_pkg.sv
// Shared constants for the IF->ID pipeline stage: default widths and the bubble instruction.
package if_id_skid_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;

    // MIPS sll $0,$0,0 doubles as the bubble instruction
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] ZEROWORD     = 32'h0000_0000;

endpackage

// File: rtl/if_id_skid_if.sv
// Valid/ready channel carrying one PC + instruction pair between pipeline stages.
interface if_id_skid_if
    import if_id_skid_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF
);

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;

    modport master (output valid, output pc, output inst, input ready);
    modport slave  (input valid, input pc, input inst, output ready);

endinterface

// File: rtl/if_id_skid_pipe_entry.sv
// Enable-loaded PC + instruction register with synchronous clear (clear wins over load).
module pipe_entry
    import if_id_skid_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [INST_W-1:0] i_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic [INST_W-1:0] o_inst
);

    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_pc   <= '0;
            r_inst <= '0;
        end else if (i_en) begin
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end
    end

    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule

// File: rtl/if_id_skid.sv
// IF->ID stage register: two-entry skid buffer with registered in_ready and flush-to-bubble.
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int unsigned         ADDR_W   = ADDR_W_DEF,
    parameter int unsigned         INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0]   NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_flush,
    if_id_skid_if.slave    i_fetch,
    if_id_skid_if.master   o_dec
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;

    logic              w_xfer_in;
    logic              w_xfer_out;
    logic              w_main_en;
    logic              w_skid_en;
    logic [ADDR_W-1:0] w_main_pc_d;
    logic [INST_W-1:0] w_main_inst_d;
    logic [ADDR_W-1:0] w_main_pc;
    logic [INST_W-1:0] w_main_inst;
    logic [ADDR_W-1:0] w_skid_pc;
    logic [INST_W-1:0] w_skid_inst;

    assign w_xfer_in  = i_fetch.valid & r_in_ready;
    assign w_xfer_out = r_out_valid & o_dec.ready;

    // Flush suppresses all loads; main keeps its PC so out_pc holds its last value.
    always_comb begin
        w_main_en     = 1'b0;
        w_skid_en     = 1'b0;
        w_main_pc_d   = i_fetch.pc;
        w_main_inst_d = i_fetch.inst;
        if (!rst && !i_flush) begin
            case (r_state)
                ST_EMPTY: w_main_en = w_xfer_in;
                ST_FULL: begin
                    w_main_en = w_xfer_in & w_xfer_out;
                    w_skid_en = w_xfer_in & ~w_xfer_out;
                end
                ST_SKID: begin
                    w_main_en     = w_xfer_out;
                    w_main_pc_d   = w_skid_pc;
                    w_main_inst_d = w_skid_inst;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_xfer_in) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_xfer_out && !w_xfer_in) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_xfer_in && !w_xfer_out) begin
                        r_state    <= ST_SKID;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (w_xfer_out) begin
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    pipe_entry #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_main (
        .clk    (clk),
        .i_clr  (rst),
        .i_en   (w_main_en),
        .i_pc   (w_main_pc_d),
        .i_inst (w_main_inst_d),
        .o_pc   (w_main_pc),
        .o_inst (w_main_inst)
    );

    pipe_entry #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
        .clk    (clk),
        .i_clr  (rst),
        .i_en   (w_skid_en),
        .i_pc   (i_fetch.pc),
        .i_inst (i_fetch.inst),
        .o_pc   (w_skid_pc),
        .o_inst (w_skid_inst)
    );

    assign i_fetch.ready = r_in_ready;
    assign o_dec.valid   = r_out_valid;
    assign o_dec.pc      = w_main_pc;
    assign o_dec.inst    = r_out_valid ? w_main_inst : NOP_INST;

endmodule

// File: tb/tb_if_id_skid.sv
// Directed checks of the IF->ID skid stage followed by a random back-pressure run against a queue.
module tb_if_id_skid;

    logic clk;
    logic rst;
    logic flush;

    int unsigned n_tests;
    int unsigned n_fail;

    if_id_skid_if #(.ADDR_W(32), .INST_W(32)) fetch_if ();
    if_id_skid_if #(.ADDR_W(32), .INST_W(32)) dec_if ();

    if_id_skid #(.ADDR_W(32), .INST_W(32), .NOP_INST(32'h0000_0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_fetch (fetch_if.slave),
        .o_dec   (dec_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic v, input logic [31:0] pc);
        fetch_if.valid = v;
        fetch_if.pc    = pc;
        fetch_if.inst  = inst_of(pc);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic rdy);
        chk({tag, ".valid"}, 64'(dec_if.valid), 64'(v));
        chk({tag, ".pc"}, 64'(dec_if.pc), 64'(pc));
        chk({tag, ".inst"}, 64'(dec_if.inst), 64'(inst));
        chk({tag, ".in_ready"}, 64'(fetch_if.ready), 64'(rdy));
    endtask

    logic [31:0] sb[$];
    logic        prev_stall;
    logic [31:0] held_pc;
    logic [31:0] held_inst;
    logic [31:0] next_pc;
    logic        xin;
    logic        xout;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        dec_if.ready = 1'b1;
        feed(1'b1, 32'h0000_0AA0);

        // reset held two cycles with valid input asserted
        tick; tick;
        chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b1);

        // streaming: one instruction per cycle, one-cycle latency
        rst = 1'b0;
        feed(1'b1, 32'h100);
        tick; chk_out("stream0", 1'b1, 32'h100, inst_of(32'h100), 1'b1);
        feed(1'b1, 32'h104);
        tick; chk_out("stream1", 1'b1, 32'h104, inst_of(32'h104), 1'b1);
        feed(1'b1, 32'h108);
        tick; chk_out("stream2", 1'b1, 32'h108, inst_of(32'h108), 1'b1);
        feed(1'b0, 32'h10C);
        tick; chk_out("drain", 1'b0, 32'h108, 32'h0, 1'b1);

        // stall captures the skid entry
        feed(1'b1, 32'h200);
        tick; chk_out("stall.load", 1'b1, 32'h200, inst_of(32'h200), 1'b1);
        feed(1'b1, 32'h204);
        dec_if.ready = 1'b0;
        tick; chk_out("stall.skid", 1'b1, 32'h200, inst_of(32'h200), 1'b0);
        feed(1'b1, 32'h2F0);
        tick; chk_out("stall.hold", 1'b1, 32'h200, inst_of(32'h200), 1'b0);
        feed(1'b0, 32'h2F4);
        dec_if.ready = 1'b1;
        tick; chk_out("stall.release", 1'b1, 32'h204, inst_of(32'h204), 1'b1);
        tick; chk_out("stall.empty", 1'b0, 32'h204, 32'h0, 1'b1);

        // flush while in SKID drops both entries and the concurrent input
        dec_if.ready = 1'b0;
        feed(1'b1, 32'h300);
        tick; chk_out("fl.main", 1'b1, 32'h300, inst_of(32'h300), 1'b1);
        feed(1'b1, 32'h304);
        tick; chk_out("fl.skid", 1'b1, 32'h300, inst_of(32'h300), 1'b0);
        feed(1'b1, 32'h308);
        flush = 1'b1;
        tick; chk_out("fl.after", 1'b0, 32'h300, 32'h0, 1'b1);
        flush = 1'b0;
        feed(1'b0, 32'h30C);
        dec_if.ready = 1'b1;
        tick; chk_out("fl.nodrop", 1'b0, 32'h300, 32'h0, 1'b1);

        // flush and reset together while FULL
        feed(1'b1, 32'h3F0);
        tick; chk_out("fr.full", 1'b1, 32'h3F0, inst_of(32'h3F0), 1'b1);
        feed(1'b1, 32'h3F4);
        flush = 1'b1;
        rst   = 1'b1;
        tick; chk_out("fr.reset", 1'b0, 32'h0, 32'h0, 1'b1);
        flush = 1'b0;
        rst   = 1'b0;
        feed(1'b1, 32'h400);
        tick; chk_out("fr.next", 1'b1, 32'h400, inst_of(32'h400), 1'b1);

        // FULL with neither transfer holds
        feed(1'b0, 32'h404);
        dec_if.ready = 1'b0;
        tick; chk_out("full.hold", 1'b1, 32'h400, inst_of(32'h400), 1'b1);
        dec_if.ready = 1'b1;
        tick; chk_out("full.empty", 1'b0, 32'h400, 32'h0, 1'b1);

        // random valid/ready back-pressure against an in-order scoreboard
        next_pc    = 32'h1000;
        prev_stall = 1'b0;
        held_pc    = '0;
        held_inst  = '0;
        for (int unsigned c = 0; c < 4000; c++) begin
            feed(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, next_pc);
            dec_if.ready = ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0;
            #2;
            if (prev_stall) begin
                chk("rnd.stable_valid", 64'(dec_if.valid), 64'd1);
                chk("rnd.stable_pc", 64'(dec_if.pc), 64'(held_pc));
                chk("rnd.stable_inst", 64'(dec_if.inst), 64'(held_inst));
            end
            xin  = fetch_if.valid & fetch_if.ready;
            xout = dec_if.valid & dec_if.ready;
            if (xout) begin
                if (sb.size() == 0) begin
                    chk("rnd.spurious", 64'(dec_if.pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("rnd.pc", 64'(dec_if.pc), 64'(sb[0]));
                    chk("rnd.inst", 64'(dec_if.inst), 64'(inst_of(sb[0])));
                    void'(sb.pop_front());
                end
            end
            if (xin) begin
                sb.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end
            prev_stall = dec_if.valid & ~dec_if.ready;
            held_pc    = dec_if.pc;
            held_inst  = dec_if.inst;
            tick;
        end

        // drain with a bounded budget
        feed(1'b0, next_pc);
        dec_if.ready = 1'b1;
        for (int unsigned c = 0; c < 8 && sb.size() != 0; c++) begin
            #2;
            if (dec_if.valid) begin
                chk("drain.pc", 64'(dec_if.pc), 64'(sb[0]));
                void'(sb.pop_front());
            end
            tick;
        end
        chk("drain.left", 64'(sb.size()), 64'd0);
        chk("drain.valid", 64'(dec_if.valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
